// File: rtl/tero_sequencer.sv
// rtl/tero_sequencer.sv - challenge-driven loop sequencer for the TERO PUF array
//
// Purpose: on start, latch a challenge and walk every TERO loop exactly once in a
// challenge-dependent order (XOR-scrambled, optionally reversed). Each loop is held
// for NUM_ROUNDS measurements; the measurement unit steps the walk with advance.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   start        one-cycle run request, honoured in IDLE or DONE
//   challenge_in challenge, sampled with an accepted start
//   advance      measurement of the current loop_sel is complete
//   abort        synchronous cancel back to IDLE, highest priority
//   loop_sel     loop to enable/measure
//   sel_valid    loop_sel is valid (ACTIVE)
//   round_idx    round within the current loop
//   seq_idx      position within the sequence
//   last         current step is the final loop and final round
//   busy         run in progress (ACTIVE)
//   done         run finished (DONE), held until start/abort/reset
module tero_sequencer #(
    parameter int NUM_LOOPS      = 32,
    parameter int CHALLENGE_BITS = 8,
    parameter int NUM_ROUNDS     = 1,
    localparam int LOOP_BITS     = $clog2(NUM_LOOPS),
    localparam int ROUND_BITS    = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [CHALLENGE_BITS-1:0] challenge_in,
    input  logic                      advance,
    input  logic                      abort,
    output logic [LOOP_BITS-1:0]      loop_sel,
    output logic                      sel_valid,
    output logic [ROUND_BITS-1:0]     round_idx,
    output logic [LOOP_BITS-1:0]      seq_idx,
    output logic                      last,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [LOOP_BITS-1:0]  SEQ_MAX   = LOOP_BITS'(NUM_LOOPS - 1);
    localparam logic [ROUND_BITS-1:0] ROUND_MAX = ROUND_BITS'(NUM_ROUNDS - 1);

    state_t                state;
    state_t                state_nxt;
    logic [LOOP_BITS-1:0]  mask;
    logic [LOOP_BITS-1:0]  mask_nxt;
    logic                  rev;
    logic                  rev_nxt;
    logic [LOOP_BITS-1:0]  seq_nxt;
    logic [ROUND_BITS-1:0] round_nxt;
    logic [LOOP_BITS-1:0]  loop_sel_nxt;
    logic                  seq_at_max;
    logic                  round_at_max;

    // NUM_LOOPS is a power of two, so NUM_LOOPS-1-pos is just the bitwise
    // complement of pos at LOOP_BITS width.
    function automatic logic [LOOP_BITS-1:0] map_loop(
        input logic [LOOP_BITS-1:0] pos,
        input logic [LOOP_BITS-1:0] m,
        input logic                 r
    );
        return (r ? ~pos : pos) ^ m;
    endfunction

    assign seq_at_max   = (seq_idx == SEQ_MAX);
    assign round_at_max = (round_idx == ROUND_MAX);

    always_comb begin
        state_nxt    = state;
        mask_nxt     = mask;
        rev_nxt      = rev;
        seq_nxt      = seq_idx;
        round_nxt    = round_idx;
        loop_sel_nxt = loop_sel;

        if (abort) begin
            state_nxt    = ST_IDLE;
            seq_nxt      = '0;
            round_nxt    = '0;
            loop_sel_nxt = '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mask_nxt     = challenge_in[LOOP_BITS-1:0];
                        rev_nxt      = challenge_in[LOOP_BITS];
                        seq_nxt      = '0;
                        round_nxt    = '0;
                        loop_sel_nxt = map_loop('0, mask_nxt, rev_nxt);
                        state_nxt    = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (advance) begin
                        if (!round_at_max) begin
                            round_nxt = round_idx + ROUND_BITS'(1);
                        end else begin
                            round_nxt = '0;
                            // The final step ends the run; seq_idx and loop_sel
                            // keep their last values instead of wrapping.
                            if (seq_at_max) begin
                                state_nxt = ST_DONE;
                            end else begin
                                seq_nxt      = seq_idx + LOOP_BITS'(1);
                                loop_sel_nxt = map_loop(seq_nxt, mask, rev);
                            end
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            mask      <= '0;
            rev       <= 1'b0;
            seq_idx   <= '0;
            round_idx <= '0;
            loop_sel  <= '0;
        end else begin
            state     <= state_nxt;
            mask      <= mask_nxt;
            rev       <= rev_nxt;
            seq_idx   <= seq_nxt;
            round_idx <= round_nxt;
            loop_sel  <= loop_sel_nxt;
        end
    end

    assign sel_valid = (state == ST_ACTIVE);
    assign busy      = (state == ST_ACTIVE);
    assign done      = (state == ST_DONE);
    assign last      = (state == ST_ACTIVE) && seq_at_max && round_at_max;

    // Challenge bits above the reverse flag do not affect the sequence.
    generate
        if (CHALLENGE_BITS > LOOP_BITS + 1) begin : g_spare_challenge
            logic unused_challenge_hi;
            assign unused_challenge_hi = ^challenge_in[CHALLENGE_BITS-1:LOOP_BITS+1];
        end
    endgenerate

endmodule

// File: tb/tb_tero_sequencer.sv
// tb/tb_tero_sequencer.sv - self-checking bench for tero_sequencer
module tb_tero_sequencer;

    localparam int N  = 8;
    localparam int R  = 2;
    localparam int CB = 4;
    localparam int LB = 3;
    localparam int RB = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          advance = 1'b0;
    logic          abort = 1'b0;
    logic [CB-1:0] challenge_in = '0;
    logic [LB-1:0] loop_sel;
    logic [LB-1:0] seq_idx;
    logic [RB-1:0] round_idx;
    logic          sel_valid;
    logic          last;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    tero_sequencer #(
        .NUM_LOOPS      (N),
        .CHALLENGE_BITS (CB),
        .NUM_ROUNDS     (R)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .challenge_in (challenge_in),
        .advance      (advance),
        .abort        (abort),
        .loop_sel     (loop_sel),
        .sel_valid    (sel_valid),
        .round_idx    (round_idx),
        .seq_idx      (seq_idx),
        .last         (last),
        .busy         (busy),
        .done         (done)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: state (0 idle, 1 active, 2 done), flat step counter k = seq*R + round.
    int m_st;
    int m_k;
    int m_mask;
    int m_rev;
    bit m_fresh;
    bit chk_en = 1'b0;
    int cap[$];
    int last_at;

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int map_seq(input int s);
        int pos;
        pos = m_rev ? (N - 1 - s) : s;
        return (pos ^ m_mask) % N;
    endfunction

    task automatic model_reset();
        m_st = 0; m_k = 0; m_mask = 0; m_rev = 0; m_fresh = 1'b1;
    endtask

    task automatic model_update(input logic s, input logic [CB-1:0] ch, input logic adv, input logic ab);
        if (ab) begin
            m_st = 0; m_k = 0; m_fresh = 1'b0;
        end else if (m_st != 1) begin
            if (s) begin
                m_mask = int'(ch) % N;
                m_rev  = (int'(ch) / N) % 2;
                m_st = 1; m_k = 0; m_fresh = 1'b0;
            end
        end else if (adv) begin
            if (m_k == N * R - 1) m_st = 2;
            else m_k++;
        end
    endtask

    task automatic check_model();
        int seq_e;
        seq_e = (m_st == 1) ? m_k / R : ((m_st == 2) ? N - 1 : 0);
        cmp("sel_valid", int'(sel_valid), int'(m_st == 1));
        cmp("busy", int'(busy), int'(m_st == 1));
        cmp("done", int'(done), int'(m_st == 2));
        cmp("last", int'(last), int'(m_st == 1 && m_k == N * R - 1));
        cmp("seq_idx", int'(seq_idx), seq_e);
        if (m_st != 2) cmp("round_idx", int'(round_idx), (m_st == 1) ? m_k % R : 0);
        if (m_st != 0) cmp("loop_sel", int'(loop_sel), map_seq(seq_e));
        else if (m_fresh) cmp("loop_sel_idle", int'(loop_sel), 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) check_model();
        if (sel_valid) begin
            cap.push_back(int'(loop_sel));
            if (last) last_at = cap.size();
        end
    end

    task automatic step(input logic s, input logic [CB-1:0] ch, input logic adv, input logic ab);
        start = s; challenge_in = ch; advance = adv; abort = ab;
        @(posedge clk);
        model_update(s, ch, adv, ab);
        #1;
        start = 1'b0; advance = 1'b0; abort = 1'b0;
    endtask

    task automatic run_check(input logic [CB-1:0] ch, input int exp_seq[N], input string tag);
        cap.delete();
        last_at = -1;
        step(1'b1, ch, 1'b0, 1'b0);
        for (int i = 0; i < N * R; i++) step(1'b0, '0, 1'b1, 1'b0);
        cmp({tag, "_done"}, int'(done), 1);
        cmp({tag, "_busy"}, int'(busy), 0);
        cmp({tag, "_len"}, cap.size(), N * R);
        cmp({tag, "_last_pos"}, last_at, N * R);
        for (int i = 0; i < N * R && i < cap.size(); i++)
            cmp({tag, "_seq"}, cap[i], exp_seq[i / R]);
    endtask

    task automatic async_reset();
        #2 reset = 1'b0;
        #1;
        cmp("ar_loop_sel", int'(loop_sel), 0);
        cmp("ar_seq_idx", int'(seq_idx), 0);
        cmp("ar_round_idx", int'(round_idx), 0);
        cmp("ar_sel_valid", int'(sel_valid), 0);
        cmp("ar_last", int'(last), 0);
        cmp("ar_busy", int'(busy), 0);
        cmp("ar_done", int'(done), 0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    int exp_id[N];
    int exp_5[N];
    int exp_b[N];

    initial begin
        bit seen[N];
        int distinct;
        exp_id = '{0, 1, 2, 3, 4, 5, 6, 7};
        exp_5  = '{5, 4, 7, 6, 1, 0, 3, 2};
        exp_b  = '{4, 5, 6, 7, 0, 1, 2, 3};

        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chk_en = 1'b1;
        cmp("rst_busy", int'(busy), 0);
        cmp("rst_done", int'(done), 0);
        cmp("rst_loop_sel", int'(loop_sel), 0);

        // Identity order, then scrambled, then reversed+scrambled.
        run_check(4'b0000, exp_id, "ch0000");
        run_check(4'b0101, exp_5, "ch0101");
        for (int i = 0; i < N; i++) seen[i] = 1'b0;
        distinct = 0;
        for (int i = 0; i < cap.size(); i += R)
            if (!seen[cap[i] % N]) begin seen[cap[i] % N] = 1'b1; distinct++; end
        cmp("perm_distinct", distinct, N);
        run_check(4'b1011, exp_b, "ch1011");

        // start in DONE: new run immediately.
        step(1'b1, 4'b0101, 1'b0, 1'b0);
        cmp("redo_done", int'(done), 0);
        cmp("redo_valid", int'(sel_valid), 1);
        cmp("redo_loop_sel", int'(loop_sel), 5);

        // abort together with advance at seq_idx 3.
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 3 * R; i++) step(1'b0, '0, 1'b1, 1'b0);
        cmp("pre_abort_seq", int'(seq_idx), 3);
        step(1'b0, '0, 1'b1, 1'b1);
        cmp("abort_valid", int'(sel_valid), 0);
        cmp("abort_done", int'(done), 0);
        cmp("abort_seq", int'(seq_idx), 0);

        // advance in IDLE does nothing.
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        cmp("idle_adv_busy", int'(busy), 0);
        cmp("idle_adv_seq", int'(seq_idx), 0);

        // start while ACTIVE is ignored; mask stays 0.
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 4'b1111, 1'b0, 1'b0);
        step(1'b1, 4'b0110, 1'b1, 1'b0);
        cmp("restart_ign_sel", int'(loop_sel), 2);
        step(1'b0, '0, 1'b1, 1'b0);
        cmp("restart_ign_sel2", int'(loop_sel), 3);

        // Mid-run asynchronous reset.
        async_reset();

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 9) == 0, CB'($urandom), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 59) == 0);
            if ($urandom_range(0, 599) == 0) async_reset();
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
